// File: rtl/chan_sel_mux.sv
// Purpose : NCH-channel WIDTH-bit selector (direct sel or round-robin) feeding one output register.
// Latency : 1 cycle from an accepted input to out_data/out_valid; full-throughput drain/refill.
// Backpres: in_ready only on the granted channel while the register is empty or draining this cycle.
// Optional: define CHSEL_XFER_CNT_EN to add the 32-bit xfer_cnt output (accepted-transfer counter).
module chan_sel_mux #(
    parameter int               WIDTH  = 64,
    parameter int               NCH    = 7,
    parameter logic [WIDTH-1:0] DEFVAL = '0,
    localparam int              SELW   = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH*WIDTH-1:0]  in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SELW-1:0]       out_chan,
    output logic                  sel_err
`ifdef CHSEL_XFER_CNT_EN
    ,
    output logic [31:0]           xfer_cnt
`endif
);

    // Output register and round-robin state
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             sel_err_q, sel_err_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    // Grant path
    logic             slot_free;
    logic             sel_oob;
    logic             rr_hi_vld, rr_lo_vld, rr_vld;
    logic [SELW-1:0]  rr_hi_idx, rr_lo_idx, rr_idx;
    logic             grant_vld;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_dat;
    logic             xfer;

    // The register can take new data when empty or when being drained this cycle
    always_comb begin
        slot_free = ~out_valid_q | out_ready;
        sel_oob   = (int'(sel) >= NCH);
    end

    // Round-robin search: first valid channel above rr_ptr, else first valid at or below it
    always_comb begin
        rr_hi_vld = 1'b0;
        rr_hi_idx = '0;
        rr_lo_vld = 1'b0;
        rr_lo_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!rr_hi_vld && in_valid[k] && (k > int'(rr_ptr_q))) begin
                rr_hi_vld = 1'b1;
                rr_hi_idx = SELW'(k);
            end
            if (!rr_lo_vld && in_valid[k] && (k <= int'(rr_ptr_q))) begin
                rr_lo_vld = 1'b1;
                rr_lo_idx = SELW'(k);
            end
        end
        rr_vld = rr_hi_vld | rr_lo_vld;
        rr_idx = rr_hi_vld ? rr_hi_idx : rr_lo_idx;
    end

    // Grant selection: direct mode ignores in_valid for the grant itself, an out-of-range sel grants nothing
    always_comb begin
        if (!mode) begin
            grant_vld = ~sel_oob;
            grant     = sel;
        end else begin
            grant_vld = rr_vld;
            grant     = rr_idx;
        end
    end

    // One-hot ready on the granted channel and the matching data slice
    always_comb begin
        in_ready  = '0;
        grant_dat = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant_vld && (int'(grant) == k)) begin
                in_ready[k] = slot_free;
                grant_dat   = in_data[k*WIDTH +: WIDTH];
            end
        end
        xfer = |(in_ready & in_valid);
    end

    // Next-state: load on transfer, otherwise hold data/chan and drop valid when drained
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q & ~out_ready;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = grant_dat;
            out_chan_d  = grant;
            out_valid_d = 1'b1;
            if (mode) begin
                rr_ptr_d = grant;
            end
        end
        sel_err_d = ~mode & sel_oob;
    end

    // State registers; rr_ptr starts at the last channel so the first round-robin grant is channel 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data_q  <= DEFVAL;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            sel_err_q   <= 1'b0;
            rr_ptr_q    <= SELW'(NCH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            sel_err_q   <= sel_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

`ifdef CHSEL_XFER_CNT_EN
    logic [31:0] xfer_cnt_q, xfer_cnt_d;

    // Accepted-transfer counter, wraps naturally at 2^32
    always_comb begin
        xfer_cnt_d = xfer_cnt_q + {31'b0, xfer};
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_chan_sel_mux.sv
// Purpose : directed bench for chan_sel_mux (NCH=7, WIDTH=64) with an expected-output scoreboard.
// Latency : each accepted input is expected on out_data/out_chan one edge later.
// Backpres: stalls, drains and out-of-range selects are driven explicitly step by step.
module tb_chan_sel_mux;

    localparam int W = 64;
    localparam int N = 7;

    logic           clk;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [2:0]     sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     out_chan;
    logic           sel_err;
`ifdef CHSEL_XFER_CNT_EN
    logic [31:0]    xfer_cnt;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic [2:0]  c;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_xfer = 0;
    int   cx;

    chan_sel_mux #(.WIDTH(W), .NCH(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .sel_err   (sel_err)
`ifdef CHSEL_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] chv(input int k);
        return 64'h100 + 64'(k);
    endfunction

    task automatic push(input logic [63:0] d, input int c);
        sb.push_back({d, 3'(c)});
        n_xfer++;
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_vld"}, 64'(out_valid), 64'd1);
            chk({tag, "_dat"}, out_data, e.d);
            chk({tag, "_chn"}, 64'(out_chan), 64'(e.c));
        end
    endtask

    initial begin
        reset     = 1'b0;
        mode      = 1'b0;
        sel       = 3'd0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_vld", 64'(out_valid), 64'd0);
        chk("rst_dat", out_data, 64'd0);
        chk("rst_chn", 64'(out_chan), 64'd0);
        chk("rst_err", 64'(sel_err), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Direct select of channel 2
        sel = 3'd2;
        in_valid = 7'b0000100;
        in_data[2*W +: W] = 64'hA5;
        out_ready = 1'b1;
        #1;
        chk("t1_rdy", 64'(in_ready), 64'(7'b0000100));
        push(64'hA5, 2);
        tick();
        pop_chk("t1");

        // Stall for 5 cycles with new data waiting on channel 2
        out_ready = 1'b0;
        in_data[2*W +: W] = 64'hB6;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_rdy", 64'(in_ready), 64'd0);
            tick();
            chk("t2_vld", 64'(out_valid), 64'd1);
            chk("t2_dat", out_data, 64'hA5);
            chk("t2_chn", 64'(out_chan), 64'd2);
        end
        out_ready = 1'b1;
        #1;
        chk("t2_rel_rdy", 64'(in_ready), 64'(7'b0000100));
        push(64'hB6, 2);
        tick();
        pop_chk("t2");

        // Drain with no refill keeps data and channel
        in_valid = '0;
        tick();
        chk("drn_vld", 64'(out_valid), 64'd0);
        chk("drn_dat", out_data, 64'hB6);
        chk("drn_chn", 64'(out_chan), 64'd2);

        // Round-robin over all channels, back to back
        mode = 1'b1;
        for (int k = 0; k < N; k++) in_data[k*W +: W] = chv(k);
        in_valid = 7'h7F;
        for (int i = 0; i < 9; i++) begin
            cx = i % 7;
            #1;
            chk("t3_rdy", 64'(in_ready), 64'(1) << cx);
            push(chv(cx), cx);
            tick();
            pop_chk("t3");
        end

        // Two valid channels, rr_ptr now 1: alternate 4,1,4,1
        in_valid = 7'b0010010;
        for (int i = 0; i < 4; i++) begin
            cx = (i % 2 == 0) ? 4 : 1;
            #1;
            chk("t4_rdy", 64'(in_ready), 64'(1) << cx);
            push(chv(cx), cx);
            tick();
            pop_chk("t4");
        end

        // Out-of-range direct select
        mode = 1'b0;
        sel = 3'd7;
        in_valid = 7'h7F;
        #1;
        chk("t5_rdy", 64'(in_ready), 64'd0);
        tick();
        chk("t5_err", 64'(sel_err), 64'd1);
        chk("t5_vld", 64'(out_valid), 64'd0);
        sel = 3'd3;
        #1;
        chk("t5_rdy3", 64'(in_ready), 64'(7'b0001000));
        push(chv(3), 3);
        tick();
        chk("t5_err0", 64'(sel_err), 64'd0);
        pop_chk("t5");

        // Back to round-robin: pointer kept at 1 through direct mode, so channel 2 next
        mode = 1'b1;
        #1;
        chk("t6_rdy", 64'(in_ready), 64'(7'b0000100));
        push(chv(2), 2);
        tick();
        pop_chk("t6");
`ifdef CHSEL_XFER_CNT_EN
        chk("cnt", 64'(xfer_cnt), 64'(n_xfer));
`endif

        // Asynchronous reset while the register is full
        out_ready = 1'b0;
        in_valid = '0;
        reset = 1'b0;
        #1;
        chk("t7_vld", 64'(out_valid), 64'd0);
        chk("t7_dat", out_data, 64'd0);
        chk("t7_chn", 64'(out_chan), 64'd0);
`ifdef CHSEL_XFER_CNT_EN
        chk("t7_cnt", 64'(xfer_cnt), 64'd0);
`endif
        tick();
        reset = 1'b1;

        // Single valid channel in round-robin: granted every cycle
        mode = 1'b1;
        in_valid = 7'b0000001;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t8_rdy", 64'(in_ready), 64'd1);
            push(chv(0), 0);
            tick();
            pop_chk("t8");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
